cache_arbiter_rr: RTL and testbench
===================================

Name: cache_arbiter_rr

Overview:
- N-port successor to the two-cache L2 bus arbiter. Multiplexes NUM_PORTS cache miss/writeback requests onto a single L2 request/response bus.
- Grants one port at a time and holds the grant until L2 returns mem_ready.
- Arbitration is either round-robin (fair) or fixed-priority (lowest index wins).
- Sits between the L1 caches (I$, D$, extra cores) and the L2 cache.

Parameters:
- NUM_PORTS, 2, number of requesting caches; must be >= 2.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 highest).
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- clock  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- req_i  input  mem_bus_req_t [NUM_PORTS]  per-port request: mem_addr, mem_data_out, mem_req_load, mem_req_store.
- resp_o  output  mem_bus_resp_t [NUM_PORTS]  per-port response: mem_data, mem_ready.
- req  output  mem_bus_req_t  request to L2.
- resp  input  mem_bus_resp_t  response from L2.
- grant_o  output  NUM_PORTS  one-hot registered grant; all zero when idle.
- busy_o  output  1  high while any port holds the bus.
- timeout_o  output  1  sticky watchdog error flag.

Behaviour:
- Reset:
  - Assertion is asynchronous, release is synchronous to clock.
  - State=IDLE, grant_o=0, busy_o=0, timeout_o=0, last_grant=NUM_PORTS-1 (port 0 wins first).
  - While reset_n=0: req.mem_req_load=0, req.mem_req_store=0, req.mem_addr=0, req.mem_data_out=0, all resp_o[i].mem_ready=0, all resp_o[i].mem_data=0.
- A port is "requesting" when req_i[i].mem_req_load | req_i[i].mem_req_store.
- FSM states: IDLE, BUSY, TURN.
- IDLE:
  - If any port is requesting, pick a winner.
  - Round-robin: first requesting index scanning last_grant+1, last_grant+2, ..., wrapping modulo NUM_PORTS.
  - Fixed priority: lowest requesting index.
  - At the clock edge: grant_o <= onehot(winner), last_grant <= winner, go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - req is a combinational pass-through of req_i[winner] (addr, data, load, store).
  - resp_o[winner].mem_data = resp.mem_data. Non-granted ports see mem_data=0 and mem_ready=0.
  - resp_o[winner].mem_ready = resp.mem_ready (combinational, same cycle).
  - When resp.mem_ready=1: go to TURN at the edge and clear grant_o. Otherwise stay in BUSY.
- TURN:
  - One dead cycle with req load/store=0. The requester drops its request after seeing ready, so no spurious re-grant can occur.
  - Always go to IDLE.
- Latency:
  - A request first visible in IDLE cycle t appears on the L2 bus in cycle t+1.
  - The minimum gap between consecutive grants is 1 TURN + 1 IDLE cycle.
- Requester rule:
  - Hold load/store, addr and data stable from assertion until the cycle mem_ready is seen.
  - Dropping the request while granted is a protocol violation, caught by a simulation assertion. The grant is held regardless.
- Simultaneous events:
  - A new request arriving in the same cycle as resp.mem_ready is ignored until the next IDLE.
  - Load and store both asserted on one port are forwarded as-is; L2 defines the result.
- Starvation bound (round-robin): a continuously requesting port is granted within NUM_PORTS grants.
- Reset mid-transaction: abandons the grant immediately. The L2 is reset in the same domain.
- busy_o = (state==BUSY).
- Invariant: at most one bit of grant_o is set (assertion, $fatal).

Optional Feature:
- Macro: CACHE_ARB_WATCHDOG_EN.
- With the macro defined:
  - A counter, width clog2(TIMEOUT_CYCLES+1), clears on entry to BUSY and increments each BUSY cycle with resp.mem_ready=0.
  - On reaching TIMEOUT_CYCLES: timeout_o <= 1 (sticky until reset) and $error reports the port and addr. The FSM keeps waiting.
- Without the macro: no counter is built and timeout_o is tied to 0.

Test Plan:
- Reset with NUM_PORTS=4 and all requests high during reset_n=0 -> req load/store=0, grant_o=4'b0000. First grant after release is port 0.
- Single port 2 load at addr 0x1234 in cycle 0, L2 ready in cycle 3 -> grant_o=4'b0100 from cycle 1, req.mem_addr=0x1234 in cycles 1-3, resp_o[2].mem_ready=1 only in cycle 3, TURN in cycle 4.
- Round-robin with all 4 ports requesting continuously, L2 ready 1 cycle after each grant -> grant order 0,1,2,3,0.
- PRIO_MODE=1 with ports 1 and 3 requesting continuously -> port 1 granted every time, port 3 never granted while port 1 requests.
- Port 0 store in BUSY with port 1 load arriving on the ready cycle -> port 1 granted after TURN+IDLE; resp_o[1].mem_data=0 until granted.
- CACHE_ARB_WATCHDOG_EN with TIMEOUT_CYCLES=8 and L2 never ready -> timeout_o rises in the 9th BUSY cycle and stays 1; grant is held.

Source files
------------

// File: rtl/cache_arbiter_rr.sv
// N-port L1-to-L2 bus arbiter: round-robin or fixed-priority grant held until mem_ready.
// Optional watchdog built only when CACHE_ARB_WATCHDOG_EN is defined.
package cache_arbiter_rr_pkg;
  typedef struct packed {
    logic [31:0] mem_addr;
    logic [31:0] mem_data_out;
    logic        mem_req_load;
    logic        mem_req_store;
  } mem_bus_req_t;

  typedef struct packed {
    logic [31:0] mem_data;
    logic        mem_ready;
  } mem_bus_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_TURN = 2'd2
  } arb_state_t;
endpackage

// Handshake: a port is valid while load|store is high; it must hold addr/data/op
// stable until the cycle its resp_o.mem_ready is seen, and drop the request after.
module cache_arbiter_rr
  import cache_arbiter_rr_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int PRIO_MODE      = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  mem_bus_req_t         req_i  [NUM_PORTS],
  output mem_bus_resp_t        resp_o [NUM_PORTS],
  output mem_bus_req_t         req,
  input  mem_bus_resp_t        resp,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic                 busy_o,
  output logic                 timeout_o,
  output arb_state_t           fsm_state
);
  localparam int IW = $clog2(NUM_PORTS);

  arb_state_t            state;
  logic [IW-1:0]         last_grant;
  logic [IW-1:0]         winner;
  logic [IW-1:0]         cand;
  logic                  found;
  logic [NUM_PORTS-1:0]  active;

  assign fsm_state = state;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign active[g] = req_i[g].mem_req_load | req_i[g].mem_req_store;

    always_comb begin
      resp_o[g] = '0;
      if (state == ST_BUSY && last_grant == IW'(g)) resp_o[g] = resp;
    end
  end

  // Round-robin scans upward from the port after last_grant; fixed priority from port 0.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = last_grant;
    if (PRIO_MODE != 0) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (!found && active[IW'(k)]) begin
          winner = IW'(k);
          found  = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        cand = (cand == IW'(NUM_PORTS - 1)) ? '0 : cand + 1'b1;
        if (!found && active[cand]) begin
          winner = cand;
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    req = '0;
    if (state == ST_BUSY) req = req_i[last_grant];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      grant_o    <= '0;
      busy_o     <= 1'b0;
      last_grant <= IW'(NUM_PORTS - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state      <= ST_BUSY;
            busy_o     <= 1'b1;
            grant_o    <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << winner;
            last_grant <= winner;
          end
        end
        ST_BUSY: begin
          if (resp.mem_ready) begin
            state   <= ST_TURN;
            busy_o  <= 1'b0;
            grant_o <= '0;
          end
        end
        ST_TURN: state <= ST_IDLE;
        default: begin
          state   <= ST_IDLE;
          busy_o  <= 1'b0;
          grant_o <= '0;
        end
      endcase
    end
  end

`ifdef CACHE_ARB_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_cnt;

  // Counter saturates at the limit; the FSM keeps waiting for L2 after the flag rises.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt    <= '0;
      timeout_o <= 1'b0;
    end else if (state != ST_BUSY) begin
      wd_cnt <= '0;
    end else if (!resp.mem_ready && wd_cnt != WW'(TIMEOUT_CYCLES)) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == WW'(TIMEOUT_CYCLES - 1)) timeout_o <= 1'b1;
    end
  end

  a_watchdog : assert property (@(posedge clock) disable iff (!reset_n)
    !(state == ST_BUSY && !resp.mem_ready && wd_cnt == WW'(TIMEOUT_CYCLES - 1)))
    else $error("L2 watchdog expired: port %0d addr %h", last_grant, req.mem_addr);
`else
  assign timeout_o = 1'b0;
`endif

  a_grant_onehot : assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(grant_o))
    else $fatal(1, "grant_o not one-hot: %b", grant_o);

  a_hold_request : assert property (@(posedge clock) disable iff (!reset_n)
    (state == ST_BUSY) |-> active[last_grant])
    else $error("port %0d dropped its request while granted", last_grant);
endmodule

// File: tb/tb_cache_arbiter_rr.sv
// Directed bench for cache_arbiter_rr: a round-robin and a fixed-priority instance, 4 ports each.
module tb_cache_arbiter_rr;
  import cache_arbiter_rr_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  mem_bus_req_t  a_req_i [4];
  mem_bus_resp_t a_resp_o [4];
  mem_bus_req_t  a_req;
  mem_bus_resp_t a_resp;
  logic [3:0]    a_grant;
  logic          a_busy, a_to;
  arb_state_t    a_st;

  mem_bus_req_t  b_req_i [4];
  mem_bus_resp_t b_resp_o [4];
  mem_bus_req_t  b_req;
  mem_bus_resp_t b_resp;
  logic [3:0]    b_grant;
  logic          b_busy, b_to;
  arb_state_t    b_st;

  int checks   = 0;
  int failures = 0;

  cache_arbiter_rr #(.NUM_PORTS(4), .PRIO_MODE(0), .TIMEOUT_CYCLES(8)) dut_rr (
    .clock(clock), .reset_n(reset_n), .req_i(a_req_i), .resp_o(a_resp_o),
    .req(a_req), .resp(a_resp), .grant_o(a_grant), .busy_o(a_busy),
    .timeout_o(a_to), .fsm_state(a_st)
  );

  cache_arbiter_rr #(.NUM_PORTS(4), .PRIO_MODE(1), .TIMEOUT_CYCLES(8)) dut_fp (
    .clock(clock), .reset_n(reset_n), .req_i(b_req_i), .resp_o(b_resp_o),
    .req(b_req), .resp(b_resp), .grant_o(b_grant), .busy_o(b_busy),
    .timeout_o(b_to), .fsm_state(b_st)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 4; i++) begin
      a_req_i[i] = '0;
      b_req_i[i] = '0;
    end
    a_resp = '0;
    b_resp = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_req_i[i].mem_req_load = 1'b1;
      a_req_i[i].mem_addr     = 32'h1000 + 32'(i);
    end
    a_resp.mem_ready = 1'b1;
    a_resp.mem_data  = 32'hDEAD_BEEF;
    tick();
    tick();
    #1;
    checks++; if (a_req.mem_req_load !== 1'b0 || a_req.mem_req_store !== 1'b0) begin failures++; $display("FAIL reset_req_op: load=%b store=%b want 0 0", a_req.mem_req_load, a_req.mem_req_store); end
    checks++; if (a_req.mem_addr !== 32'h0 || a_req.mem_data_out !== 32'h0) begin failures++; $display("FAIL reset_req_bus: addr=%h data=%h want 0 0", a_req.mem_addr, a_req.mem_data_out); end
    checks++; if (a_grant !== 4'b0000 || a_busy !== 1'b0 || a_to !== 1'b0) begin failures++; $display("FAIL reset_flags: grant=%b busy=%b timeout=%b want 0000 0 0", a_grant, a_busy, a_to); end
    checks++; if ({a_resp_o[0], a_resp_o[1], a_resp_o[2], a_resp_o[3]} !== '0) begin failures++; $display("FAIL reset_resp: resp_o not all zero (port0 data=%h ready=%b)", a_resp_o[0].mem_data, a_resp_o[0].mem_ready); end
    tick();
    reset_n = 1'b1;
    a_resp = '0;
    #1;
    checks++; if (a_st !== ST_IDLE || a_grant !== 4'b0000) begin failures++; $display("FAIL release_idle: state=%0d grant=%b want 0 0000", a_st, a_grant); end
    tick();
    #1;
    checks++; if (a_grant !== 4'b0001 || a_busy !== 1'b1) begin failures++; $display("FAIL first_grant: grant=%b busy=%b want 0001 1", a_grant, a_busy); end
    checks++; if (a_req.mem_addr !== 32'h1000) begin failures++; $display("FAIL first_addr: addr=%h want 00001000", a_req.mem_addr); end
    a_resp.mem_ready = 1'b1;
    #1;
    checks++; if (a_resp_o[0].mem_ready !== 1'b1 || a_resp_o[1].mem_ready !== 1'b0) begin failures++; $display("FAIL first_ready: p0=%b p1=%b want 1 0", a_resp_o[0].mem_ready, a_resp_o[1].mem_ready); end
    tick();
    idle_inputs();
    #1;
    checks++; if (a_st !== ST_TURN || a_grant !== 4'b0000 || a_req.mem_req_load !== 1'b0) begin failures++; $display("FAIL first_turn: state=%0d grant=%b load=%b want 2 0000 0", a_st, a_grant, a_req.mem_req_load); end
    tick();
  endtask

  // Port 2 load at 0x1234 in cycle 0, L2 ready in cycle 3 (last grant was port 0).
  task automatic test_single_load();
    idle_inputs();
    a_req_i[2].mem_req_load = 1'b1;
    a_req_i[2].mem_addr     = 32'h1234;
    #1;
    checks++; if (a_req.mem_req_load !== 1'b0 || a_st !== ST_IDLE) begin failures++; $display("FAIL single_c0: load=%b state=%0d want 0 0", a_req.mem_req_load, a_st); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) begin
        a_resp.mem_ready = 1'b1;
        a_resp.mem_data  = 32'hCAFE_0003;
      end
      #1;
      checks++; if (a_grant !== 4'b0100 || a_req.mem_addr !== 32'h1234 || a_req.mem_req_load !== 1'b1) begin failures++; $display("FAIL single_busy c%0d: grant=%b addr=%h load=%b want 0100 1234 1", c, a_grant, a_req.mem_addr, a_req.mem_req_load); end
      checks++; if (a_resp_o[2].mem_ready !== (c == 3)) begin failures++; $display("FAIL single_ready c%0d: ready=%b want %b", c, a_resp_o[2].mem_ready, (c == 3)); end
    end
    checks++; if (a_resp_o[2].mem_data !== 32'hCAFE_0003 || a_resp_o[0].mem_data !== 32'h0) begin failures++; $display("FAIL single_data: p2=%h p0=%h want cafe0003 0", a_resp_o[2].mem_data, a_resp_o[0].mem_data); end
    tick();
    idle_inputs();
    #1;
    checks++; if (a_st !== ST_TURN || a_grant !== 4'b0000 || a_resp_o[2].mem_ready !== 1'b0) begin failures++; $display("FAIL single_turn: state=%0d grant=%b ready=%b want 2 0000 0", a_st, a_grant, a_resp_o[2].mem_ready); end
    tick();
    #1;
    checks++; if (a_st !== ST_IDLE) begin failures++; $display("FAIL single_idle: state=%0d want 0", a_st); end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      a_req_i[i].mem_req_load = 1'b1;
      a_req_i[i].mem_addr     = 32'h1000 + 32'(i);
    end
    do_reset();
    for (int n = 0; n < 5; n++) begin
      tick();
      #1;
      checks++; if (a_grant !== (4'b0001 << order[n]) || a_req.mem_addr !== 32'h1000 + 32'(order[n])) begin failures++; $display("FAIL rr_grant n%0d: grant=%b addr=%h want port %0d", n, a_grant, a_req.mem_addr, order[n]); end
      tick();
      a_resp.mem_ready = 1'b1;
      #1;
      checks++; if (a_resp_o[order[n]].mem_ready !== 1'b1 || a_resp_o[(order[n] + 1) % 4].mem_ready !== 1'b0) begin failures++; $display("FAIL rr_ready n%0d: winner=%b other=%b want 1 0", n, a_resp_o[order[n]].mem_ready, a_resp_o[(order[n] + 1) % 4].mem_ready); end
      tick();
      a_resp.mem_ready = 1'b0;
      #1;
      checks++; if (a_grant !== 4'b0000 || a_st !== ST_TURN) begin failures++; $display("FAIL rr_turn n%0d: grant=%b state=%0d want 0000 2", n, a_grant, a_st); end
      tick();
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_fixed_priority();
    idle_inputs();
    b_req_i[1].mem_req_load = 1'b1;
    b_req_i[1].mem_addr     = 32'h11;
    b_req_i[3].mem_req_load = 1'b1;
    b_req_i[3].mem_addr     = 32'h33;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      tick();
      #1;
      checks++; if (b_grant !== 4'b0010 || b_req.mem_addr !== 32'h11) begin failures++; $display("FAIL fp_grant n%0d: grant=%b addr=%h want 0010 11", n, b_grant, b_req.mem_addr); end
      tick();
      b_resp.mem_ready = 1'b1;
      #1;
      checks++; if (b_resp_o[1].mem_ready !== 1'b1 || b_resp_o[3].mem_ready !== 1'b0) begin failures++; $display("FAIL fp_ready n%0d: p1=%b p3=%b want 1 0", n, b_resp_o[1].mem_ready, b_resp_o[3].mem_ready); end
      tick();
      b_resp.mem_ready = 1'b0;
      tick();
    end
    b_req_i[1] = '0;
    tick();
    #1;
    checks++; if (b_grant !== 4'b1000 || b_req.mem_addr !== 32'h33) begin failures++; $display("FAIL fp_low_port: grant=%b addr=%h want 1000 33", b_grant, b_req.mem_addr); end
    b_resp.mem_ready = 1'b1;
    tick();
    idle_inputs();
    tick();
  endtask

  // Port 1 load arrives on the cycle L2 completes port 0's store.
  task automatic test_back_to_back();
    idle_inputs();
    do_reset();
    a_req_i[0].mem_req_store = 1'b1;
    a_req_i[0].mem_addr      = 32'h2000;
    a_req_i[0].mem_data_out  = 32'h55;
    tick();
    #1;
    checks++; if (a_grant !== 4'b0001 || a_req.mem_req_store !== 1'b1 || a_req.mem_req_load !== 1'b0 || a_req.mem_data_out !== 32'h55) begin failures++; $display("FAIL b2b_store: grant=%b st=%b ld=%b data=%h want 0001 1 0 55", a_grant, a_req.mem_req_store, a_req.mem_req_load, a_req.mem_data_out); end
    tick();
    a_resp.mem_ready = 1'b1;
    a_resp.mem_data  = 32'hABCD;
    a_req_i[1].mem_req_load = 1'b1;
    a_req_i[1].mem_addr     = 32'h3000;
    #1;
    checks++; if (a_resp_o[1].mem_data !== 32'h0 || a_resp_o[0].mem_data !== 32'hABCD || a_req.mem_addr !== 32'h2000) begin failures++; $display("FAIL b2b_ready: p1=%h p0=%h addr=%h want 0 abcd 2000", a_resp_o[1].mem_data, a_resp_o[0].mem_data, a_req.mem_addr); end
    tick();
    a_req_i[0] = '0;
    a_resp.mem_ready = 1'b0;
    #1;
    checks++; if (a_st !== ST_TURN || a_resp_o[1].mem_data !== 32'h0 || a_req.mem_req_load !== 1'b0) begin failures++; $display("FAIL b2b_turn: state=%0d p1=%h load=%b want 2 0 0", a_st, a_resp_o[1].mem_data, a_req.mem_req_load); end
    tick();
    #1;
    checks++; if (a_st !== ST_IDLE || a_grant !== 4'b0000) begin failures++; $display("FAIL b2b_idle: state=%0d grant=%b want 0 0000", a_st, a_grant); end
    tick();
    a_resp.mem_ready = 1'b1;
    #1;
    checks++; if (a_grant !== 4'b0010 || a_req.mem_addr !== 32'h3000 || a_resp_o[1].mem_data !== 32'hABCD || a_resp_o[1].mem_ready !== 1'b1) begin failures++; $display("FAIL b2b_second: grant=%b addr=%h data=%h ready=%b want 0010 3000 abcd 1", a_grant, a_req.mem_addr, a_resp_o[1].mem_data, a_resp_o[1].mem_ready); end
    tick();
    idle_inputs();
    tick();
  endtask

  // L2 stalls for 12 cycles; timeout only exists in the watchdog build.
  task automatic test_stall();
    logic exp_to;
    idle_inputs();
    do_reset();
    a_req_i[3].mem_req_load = 1'b1;
    a_req_i[3].mem_addr     = 32'h4444;
    tick();
    for (int b = 1; b <= 12; b++) begin
`ifdef CACHE_ARB_WATCHDOG_EN
      exp_to = (b >= 9);
`else
      exp_to = 1'b0;
`endif
      #1;
      checks++; if (a_grant !== 4'b1000 || a_busy !== 1'b1 || a_to !== exp_to) begin failures++; $display("FAIL stall b%0d: grant=%b busy=%b timeout=%b want 1000 1 %b", b, a_grant, a_busy, a_to, exp_to); end
      tick();
    end
    a_resp.mem_ready = 1'b1;
    #1;
    checks++; if (a_resp_o[3].mem_ready !== 1'b1) begin failures++; $display("FAIL stall_release: ready=%b want 1", a_resp_o[3].mem_ready); end
    tick();
    idle_inputs();
    tick();
    #1;
    checks++; if (a_st !== ST_IDLE || a_to !== exp_to) begin failures++; $display("FAIL stall_after: state=%0d timeout=%b want 0 %b", a_st, a_to, exp_to); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_load();
    test_round_robin();
    test_fixed_priority();
    test_back_to_back();
    test_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
